key_event_queue: RTL and testbench



---
 rtl/lock_pkg.sv | 23 ++
 rtl/key_fifo.sv | 64 ++++++
 rtl/key_event_queue.sv | 132 +++++++++++++
 tb/tb_key_event_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock datapath.
// Includes the key detector states and the lock controller state encoding.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } keystate_t;

  typedef enum logic [2:0] {
    LOCK_INIT,
    LOCK_LOCKED,
    LOCK_ENTRY,
    LOCK_OPEN,
    LOCK_ALARM
  } state_t;

  localparam logic [4:0] KEY_ENTER = 5'd16;
  localparam logic [4:0] KEY_MAX   = 5'd19;

endpackage

// File: rtl/key_fifo.sv
// Small show-ahead FIFO for key events with a sticky overflow flag.
// A push into an empty queue becomes visible on the following cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Keypad front end: synchronise, debounce and priority-encode the buttons,
// then queue exactly one key event per debounced press.
module key_event_queue
  import lock_pkg::*;
#(
  parameter int NKEYS           = 20,
  parameter int CODE_W          = 5,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NKEYS-1:0]              pb,
  output logic                          key_valid,
  output logic [CODE_W-1:0]             key_code,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0]  sync_meta;
  logic [NKEYS-1:0]  sync_q;
  logic              any;
  logic [CODE_W-1:0] code;

  keystate_t         state;
  keystate_t         state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_next;
  logic              push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pb;
      sync_q    <= sync_meta;
    end
  end

  assign any = |sync_q;

  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (sync_q[i]) begin
        code = CODE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
          cand_next  = code;
        end
      end
      DEBOUNCE: begin
        if (!any || (code != cand)) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          push       = 1'b1;
          state_next = HELD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        // Extra or changed keys while held are deliberately ignored.
        if (!any) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        if (any) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (cand),
    .pop      (key_ready),
    .dout     (key_code),
    .valid    (key_valid),
    .count    (fifo_count),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: expected codes go into a scoreboard
// queue and a negedge monitor compares every accepted event against it.
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] pb = '0;
  logic        key_ready = 1'b0;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  logic       prev_hold = 1'b0;
  logic [4:0] prev_code = '0;

  key_event_queue dut (
    .clk        (clk),
    .rst        (rst),
    .pb         (pb),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: handshake values are stable here, half a cycle before the pop edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_output("stall_valid", key_valid, 1);
        check_output("stall_code", key_code, prev_code);
      end
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event actual=%0d expected=none", key_code);
        end else begin
          check_output("event_code", key_code, exp_q.pop_front());
        end
      end
      prev_hold = key_valid && !key_ready;
      prev_code = key_code;
    end
  end

  task automatic apply_stimulus(input int key, input bit expect_event);
    if (expect_event) exp_q.push_back(5'(key));
    pb[key] = 1'b1;
    step(8);
    pb[key] = 1'b0;
    step(8);
  endtask

  task automatic drain_fifo();
    key_ready = 1'b1;
    for (int i = 0; i < 20 && key_valid; i++) step(1);
    check_output("drain_valid", key_valid, 0);
    check_output("drain_scoreboard", exp_q.size(), 0);
    key_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    check_output("rst_valid", key_valid, 0);
    check_output("rst_code", key_code, 0);
    check_output("rst_count", fifo_count, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_busy", busy, 0);
    step(2);
    rst = 1'b0;

    // Clean press: exact latency, then a long release adds nothing.
    exp_q.push_back(5'd5);
    pb[5] = 1'b1;
    step(5);
    check_output("latency_edge5_valid", key_valid, 0);
    step(1);
    check_output("latency_edge6_valid", key_valid, 1);
    check_output("clean_code", key_code, 5);
    check_output("clean_count", fifo_count, 1);
    step(4);
    pb[5] = 1'b0;
    step(10);
    check_output("clean_no_repeat", fifo_count, 1);
    check_output("clean_idle", busy, 0);
    drain_fifo();

    // Bounce rejection.
    repeat (3) begin
      pb[3] = 1'b1;
      step(2);
      pb[3] = 1'b0;
      step(1);
    end
    step(8);
    check_output("bounce_count", fifo_count, 0);
    check_output("bounce_valid", key_valid, 0);
    check_output("bounce_busy", busy, 0);

    // Priority and hold.
    exp_q.push_back(5'd16);
    pb[2] = 1'b1;
    pb[16] = 1'b1;
    step(8);
    check_output("prio_count", fifo_count, 1);
    check_output("prio_code", key_code, 16);
    pb[7] = 1'b1;
    step(8);
    check_output("held_ignore", fifo_count, 1);
    pb = '0;
    step(10);
    check_output("prio_release_busy", busy, 0);
    apply_stimulus(7, 1'b1);
    check_output("second_count", fifo_count, 2);
    drain_fifo();

    // Push and pop together while full.
    for (int k = 1; k <= 4; k++) apply_stimulus(k, 1'b1);
    check_output("full_count", fifo_count, 4);
    exp_q.push_back(5'd6);
    pb[6] = 1'b1;
    step(5);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    check_output("pushpop_count", fifo_count, 4);
    check_output("pushpop_overflow", overflow, 0);
    check_output("pushpop_head", key_code, 2);
    pb[6] = 1'b0;
    step(8);
    drain_fifo();

    // Overflow: fifth press is dropped.
    do_reset();
    for (int k = 1; k <= 4; k++) apply_stimulus(k, 1'b1);
    apply_stimulus(5, 1'b0);
    check_output("ovf_count", fifo_count, 4);
    check_output("ovf_flag", overflow, 1);
    check_output("ovf_head", key_code, 1);
    key_ready = 1'b1;
    step(4);
    check_output("ovf_drained_valid", key_valid, 0);
    check_output("ovf_drained_count", fifo_count, 0);
    step(3);
    check_output("empty_ready_count", fifo_count, 0);
    check_output("ovf_sticky", overflow, 1);
    key_ready = 1'b0;
    check_output("ovf_scoreboard", exp_q.size(), 0);

    // Reset in the middle of a debounce with two events queued.
    do_reset();
    apply_stimulus(1, 1'b1);
    apply_stimulus(2, 1'b1);
    check_output("pre_rst_count", fifo_count, 2);
    pb[9] = 1'b1;
    step(3);
    check_output("pre_rst_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_output("midrst_valid", key_valid, 0);
    check_output("midrst_code", key_code, 0);
    check_output("midrst_count", fifo_count, 0);
    check_output("midrst_overflow", overflow, 0);
    check_output("midrst_busy", busy, 0);
    step(2);
    rst = 1'b0;
    exp_q.push_back(5'd9);
    step(5);
    check_output("post_rst_edge5_valid", key_valid, 0);
    step(1);
    check_output("post_rst_edge6_valid", key_valid, 1);
    check_output("post_rst_code", key_code, 9);
    pb[9] = 1'b0;
    step(10);
    drain_fifo();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
